// File: rtl/jtkicker_vtimer_adj_pkg.sv
// Shared timing defaults (Kicker / Yie Ar) and the modular window helpers
// used by the video timer and its window comparators.
package jtkicker_vtimer_adj_pkg;

  localparam int DEF_CW       = 9;
  localparam int DEF_HCNT_END = 383;
  localparam int DEF_HB_START = 255;
  localparam int DEF_HB_END   = 383;
  localparam int DEF_HS_START = 300;
  localparam int DEF_HS_END   = 318;
  localparam int DEF_VCNT_END = 263;
  localparam int DEF_VB_START = 239;
  localparam int DEF_VB_END   = 15;
  localparam int DEF_VS_START = 254;
  localparam int DEF_VS_END   = 2;
  localparam int DEF_AHEAD    = 1;
  localparam int DEF_AW       = 4;

  // Half-open modular window [wstart, wend); an empty window is never active.
  function automatic logic in_window(input int pos, input int wstart, input int wend);
    if (wstart == wend) return 1'b0;
    if (wstart < wend) return (pos >= wstart) && (pos < wend);
    return (pos >= wstart) || (pos < wend);
  endfunction

  // base + signed off, folded back into 0..period-1 (|off| < period).
  function automatic int wrap_add(input int base, input int off, input int period);
    int s;
    s = base + off;
    if (s < 0) s = s + period;
    else if (s >= period) s = s - period;
    return s;
  endfunction

endpackage

// File: rtl/jtkicker_vtimer_adj_if.sv
// Video timing bus: pixel enable and sync adjust in, counters and flags out.
interface jtkicker_vtimer_adj_if
  import jtkicker_vtimer_adj_pkg::*;
#(
  parameter int CW = DEF_CW,
  parameter int AW = DEF_AW
) ();
  logic          pxl_cen;
  logic [AW-1:0] hadj;
  logic [AW-1:0] vadj;
  logic [CW-1:0] hdump;
  logic [CW-1:0] vdump;
  logic [CW-1:0] vrender;
  logic [CW-1:0] vrender1;
  logic          hinit;
  logic          vinit;
  logic          LHBL;
  logic          LVBL;
  logic          HS;
  logic          VS;

  modport master (
    input  pxl_cen, hadj, vadj,
    output hdump, vdump, vrender, vrender1, hinit, vinit, LHBL, LVBL, HS, VS
  );

  modport slave (
    output pxl_cen, hadj, vadj,
    input  hdump, vdump, vrender, vrender1, hinit, vinit, LHBL, LVBL, HS, VS
  );
endinterface

// File: rtl/jtkicker_vtimer_adj_win.sv
// Modular window comparator: is pos inside [win_start+offset, win_end+offset)
// taken modulo PERIOD.
module jtkicker_vtimer_adj_win
  import jtkicker_vtimer_adj_pkg::*;
#(
  parameter int CW     = DEF_CW,
  parameter int PERIOD = DEF_HCNT_END + 1
) (
  input  logic [CW-1:0]        pos,
  input  logic [CW-1:0]        win_start,
  input  logic [CW-1:0]        win_end,
  input  logic signed [CW+1:0] offset,
  output logic                 active
);

  // Shift both edges by the same offset, then test membership.
  always_comb begin
    active = in_window(int'(pos),
                       wrap_add(int'(win_start), int'(offset), PERIOD),
                       wrap_add(int'(win_end), int'(offset), PERIOD));
  end

endmodule

// File: rtl/jtkicker_vtimer_adj.sv
// Video timing generator with frame-latched signed H/V sync centring.
// Flags are computed from the next counter values so they are registered
// alongside the counters and always describe the count shown in the same cycle.
module jtkicker_vtimer_adj
  import jtkicker_vtimer_adj_pkg::*;
#(
  parameter int CW       = DEF_CW,
  parameter int HCNT_END = DEF_HCNT_END,
  parameter int HB_START = DEF_HB_START,
  parameter int HB_END   = DEF_HB_END,
  parameter int HS_START = DEF_HS_START,
  parameter int HS_END   = DEF_HS_END,
  parameter int VCNT_END = DEF_VCNT_END,
  parameter int VB_START = DEF_VB_START,
  parameter int VB_END   = DEF_VB_END,
  parameter int VS_START = DEF_VS_START,
  parameter int VS_END   = DEF_VS_END,
  parameter int AHEAD    = DEF_AHEAD,
  parameter int AW       = DEF_AW
) (
  input logic                   clk,
  input logic                   rst_n,
  jtkicker_vtimer_adj_if.master vid
);

  localparam int HP = HCNT_END + 1;
  localparam int VP = VCNT_END + 1;
  localparam logic [CW-1:0] H_LAST  = CW'(HCNT_END);
  localparam logic [CW-1:0] V_LAST  = CW'(VCNT_END);
  localparam logic [CW-1:0] VR_RST  = CW'(AHEAD % VP);
  localparam logic [CW-1:0] VR1_RST = CW'((AHEAD + 1) % VP);
  localparam logic LHBL_RST = !in_window(0, HB_START, HB_END);
  localparam logic LVBL_RST = !in_window(0, VB_START, VB_END);
  localparam logic HS_RST   = in_window(0, HS_START, HS_END);
  localparam logic VS_RST   = in_window(0, VS_START, VS_END);

  if (HCNT_END >= (1 << CW) || VCNT_END >= (1 << CW)) begin : g_bad_cw
    $error("count end does not fit in CW bits");
  end
  if (HB_START > HCNT_END || HB_END > HCNT_END ||
      HS_START > HCNT_END || HS_END > HCNT_END) begin : g_bad_hpos
    $error("horizontal position beyond HCNT_END");
  end
  if (VB_START > VCNT_END || VB_END > VCNT_END ||
      VS_START > VCNT_END || VS_END > VCNT_END) begin : g_bad_vpos
    $error("vertical position beyond VCNT_END");
  end
  if ((1 << (AW - 1)) >= HP || (1 << (AW - 1)) >= VP) begin : g_bad_aw
    $error("adjust range not smaller than the H/V period");
  end
  if (AHEAD > VCNT_END) begin : g_bad_ahead
    $error("AHEAD beyond VCNT_END");
  end

  logic [CW-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [CW-1:0] vr_q, vr_d, vr1_q, vr1_d;
  logic [AW-1:0] ha_q, ha_d, va_q, va_d;
  logic          lhbl_q, lhbl_d, lvbl_q, lvbl_d, hs_q, hs_d, vs_q, vs_d;
  logic          hinit_q, hinit_d, vinit_q, vinit_d;
  logic signed [CW+1:0] ha_x, va_x;
  logic [CW-1:0] hs_start_eff;
  logic          hb_act, vb_act, hs_act, vs_act;

  function automatic logic [CW-1:0] vinc(input logic [CW-1:0] x);
    return (x == V_LAST) ? '0 : x + CW'(1);
  endfunction

  // Counter advance; adjust registers latch on the last pixel of the frame.
  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    vr_d   = vr_q;
    vr1_d  = vr1_q;
    ha_d   = ha_q;
    va_d   = va_q;
    if (vid.pxl_cen) begin
      if (vinit_q) begin
        ha_d = vid.hadj;
        va_d = vid.vadj;
      end
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = vinc(vcnt_q);
        vr_d   = vinc(vr_q);
        vr1_d  = vinc(vr1_q);
      end else begin
        hcnt_d = hcnt_q + CW'(1);
      end
    end
  end

  assign ha_x = signed'({{(CW + 2 - AW){ha_d[AW-1]}}, ha_d});
  assign va_x = signed'({{(CW + 2 - AW){va_d[AW-1]}}, va_d});

  // Effective HS start, used to keep VS edges aligned to HS.
  always_comb begin
    hs_start_eff = CW'(wrap_add(HS_START, int'(ha_x), HP));
  end

  jtkicker_vtimer_adj_win #(.CW(CW), .PERIOD(HP)) u_hb (
    .pos(hcnt_d), .win_start(CW'(HB_START)), .win_end(CW'(HB_END)),
    .offset('0), .active(hb_act)
  );
  jtkicker_vtimer_adj_win #(.CW(CW), .PERIOD(VP)) u_vb (
    .pos(vcnt_d), .win_start(CW'(VB_START)), .win_end(CW'(VB_END)),
    .offset('0), .active(vb_act)
  );
  jtkicker_vtimer_adj_win #(.CW(CW), .PERIOD(HP)) u_hs (
    .pos(hcnt_d), .win_start(CW'(HS_START)), .win_end(CW'(HS_END)),
    .offset(ha_x), .active(hs_act)
  );
  jtkicker_vtimer_adj_win #(.CW(CW), .PERIOD(VP)) u_vs (
    .pos(vcnt_d), .win_start(CW'(VS_START)), .win_end(CW'(VS_END)),
    .offset(va_x), .active(vs_act)
  );

  // Flags for the count about to be presented.
  always_comb begin
    lhbl_d  = lhbl_q;
    lvbl_d  = lvbl_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    hinit_d = hinit_q;
    vinit_d = vinit_q;
    if (vid.pxl_cen) begin
      lhbl_d  = ~hb_act;
      lvbl_d  = ~vb_act;
      hs_d    = hs_act;
      if (hcnt_d == hs_start_eff) vs_d = vs_act;
      hinit_d = (hcnt_d == H_LAST);
      vinit_d = (hcnt_d == H_LAST) && (vcnt_d == V_LAST);
    end
  end

  // State register with asynchronous reset to the (0,0) zero-adjust state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      vr_q    <= VR_RST;
      vr1_q   <= VR1_RST;
      ha_q    <= '0;
      va_q    <= '0;
      lhbl_q  <= LHBL_RST;
      lvbl_q  <= LVBL_RST;
      hs_q    <= HS_RST;
      vs_q    <= VS_RST;
      hinit_q <= 1'b0;
      vinit_q <= 1'b0;
    end else begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      vr_q    <= vr_d;
      vr1_q   <= vr1_d;
      ha_q    <= ha_d;
      va_q    <= va_d;
      lhbl_q  <= lhbl_d;
      lvbl_q  <= lvbl_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      hinit_q <= hinit_d;
      vinit_q <= vinit_d;
    end
  end

  assign vid.hdump    = hcnt_q;
  assign vid.vdump    = vcnt_q;
  assign vid.vrender  = vr_q;
  assign vid.vrender1 = vr1_q;
  assign vid.hinit    = hinit_q;
  assign vid.vinit    = vinit_q;
  assign vid.LHBL     = lhbl_q;
  assign vid.LVBL     = lvbl_q;
  assign vid.HS       = hs_q;
  assign vid.VS       = vs_q;

endmodule

// File: tb/tb_jtkicker_vtimer_adj.sv
// Directed bench on a scaled-down raster (48 x 20) so whole frames stay short.
// H: blank [31,47), HS [36,40). V: blank [15,2), VS [17,1). AHEAD=2, AW=4.
module tb_jtkicker_vtimer_adj;
  localparam int CW = 6;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jtkicker_vtimer_adj_if #(.CW(CW), .AW(AW)) vid ();

  jtkicker_vtimer_adj #(
    .CW(CW), .HCNT_END(47), .HB_START(31), .HB_END(47), .HS_START(36), .HS_END(40),
    .VCNT_END(19), .VB_START(15), .VB_END(2), .VS_START(17), .VS_END(1),
    .AHEAD(2), .AW(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vid(vid)
  );

  int n_pass = 0;
  int n_chk  = 0;

  // per-frame observations
  int seq_err, vr_err, n_hinit, hinit_bad, n_vinit, vinit_h, vinit_v, vs_bad;
  logic [47:0] hs_line, lhbl_line;
  logic [19:0] lvbl_mask, vs_mask;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int h, input int v);
    int k;
    k = 0;
    while (!(vid.hdump == CW'(h) && vid.vdump == CW'(v)) && k < 3000) begin
      step();
      k++;
    end
    n_chk++;
    if (k >= 3000) $display("FAIL goto(%0d,%0d): timeout at hdump=%0d vdump=%0d", h, v, vid.hdump, vid.vdump);
    else n_pass++;
  endtask

  // Runs one full frame from (0,0) with pxl_cen high, collecting observations.
  task automatic run_frame(input int hs_s);
    int ph, pv, h, v, eh, ev;
    logic pvs;
    seq_err = 0; vr_err = 0; n_hinit = 0; hinit_bad = 0; n_vinit = 0;
    vinit_h = -1; vinit_v = -1; vs_bad = 0;
    hs_line = '0; lhbl_line = '0; lvbl_mask = '0; vs_mask = '0;
    for (int i = 0; i < 960; i++) begin
      ph = int'(vid.hdump); pv = int'(vid.vdump); pvs = vid.VS;
      step();
      h = int'(vid.hdump); v = int'(vid.vdump);
      eh = (ph == 47) ? 0 : ph + 1;
      ev = (ph == 47) ? ((pv == 19) ? 0 : pv + 1) : pv;
      if (h != eh || v != ev) seq_err++;
      if (int'(vid.vrender) != (v + 2) % 20 || int'(vid.vrender1) != (v + 3) % 20) vr_err++;
      if (vid.hinit) begin
        n_hinit++;
        if (h != 47) hinit_bad++;
      end
      if (vid.vinit) begin
        n_vinit++; vinit_h = h; vinit_v = v;
      end
      if (h < 48 && v < 20) begin
        if (v == 1) begin
          hs_line[h] = vid.HS;
          lhbl_line[h] = vid.LHBL;
        end
        if (h == 0) lvbl_mask[v] = vid.LVBL;
        if (h == hs_s) vs_mask[v] = vid.VS;
      end
      if (vid.VS !== pvs && h != hs_s) vs_bad++;
    end
  endtask

  task automatic test_reset();
    vid.pxl_cen = 1'b1; vid.hadj = '0; vid.vadj = '0;
    rst_n = 1'b0;
    repeat (3) step();
    n_chk++; if (vid.hdump !== 6'd0) $display("FAIL reset_hdump: got %0d want 0", vid.hdump); else n_pass++;
    n_chk++; if (vid.vdump !== 6'd0) $display("FAIL reset_vdump: got %0d want 0", vid.vdump); else n_pass++;
    n_chk++; if (vid.vrender !== 6'd2) $display("FAIL reset_vrender: got %0d want 2", vid.vrender); else n_pass++;
    n_chk++; if (vid.vrender1 !== 6'd3) $display("FAIL reset_vrender1: got %0d want 3", vid.vrender1); else n_pass++;
    n_chk++; if ({vid.LHBL, vid.LVBL, vid.HS, vid.VS} !== 4'b1001)
      $display("FAIL reset_flags: got LHBL,LVBL,HS,VS=%b want 1001", {vid.LHBL, vid.LVBL, vid.HS, vid.VS}); else n_pass++;
    n_chk++; if ({vid.hinit, vid.vinit} !== 2'b00)
      $display("FAIL reset_inits: got %b want 00", {vid.hinit, vid.vinit}); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_free_run();
    run_frame(36);
    n_chk++; if (seq_err != 0) $display("FAIL free_seq: %0d counter steps wrong, want 0", seq_err); else n_pass++;
    n_chk++; if (vid.hdump !== 6'd0 || vid.vdump !== 6'd0)
      $display("FAIL free_period: after 960 pixels at (%0d,%0d) want (0,0)", vid.hdump, vid.vdump); else n_pass++;
    n_chk++; if (lhbl_line !== 48'h80007FFFFFFF) $display("FAIL free_lhbl: got %h want 80007fffffff", lhbl_line); else n_pass++;
    n_chk++; if (lvbl_mask !== 20'h07FFC) $display("FAIL free_lvbl: got %h want 07ffc", lvbl_mask); else n_pass++;
    n_chk++; if (hs_line !== 48'h00F000000000) $display("FAIL free_hs: got %h want 00f000000000", hs_line); else n_pass++;
    n_chk++; if (vs_mask !== 20'hE0001) $display("FAIL free_vs: got %h want e0001", vs_mask); else n_pass++;
    n_chk++; if (vs_bad != 0) $display("FAIL free_vs_align: %0d VS edges off HS start, want 0", vs_bad); else n_pass++;
    n_chk++; if (n_hinit != 20 || hinit_bad != 0)
      $display("FAIL free_hinit: got %0d pulses (%0d misplaced) want 20 (0)", n_hinit, hinit_bad); else n_pass++;
    n_chk++; if (n_vinit != 1 || vinit_h != 47 || vinit_v != 19)
      $display("FAIL free_vinit: got %0d pulses at (%0d,%0d) want 1 at (47,19)", n_vinit, vinit_h, vinit_v); else n_pass++;
    n_chk++; if (vr_err != 0) $display("FAIL free_vrender: %0d bad vrender samples, want 0", vr_err); else n_pass++;
  endtask

  task automatic test_adjust_deferred();
    vid.hadj = 4'sd3;
    run_frame(36);
    n_chk++; if (hs_line !== 48'h00F000000000) $display("FAIL defer_hs_same: got %h want 00f000000000", hs_line); else n_pass++;
    vid.hadj = 4'sd0;
    run_frame(39);
    n_chk++; if (hs_line !== 48'h078000000000) $display("FAIL defer_hs_new: got %h want 078000000000", hs_line); else n_pass++;
    n_chk++; if (vs_bad != 0) $display("FAIL defer_vs_align: %0d VS edges off HS start, want 0", vs_bad); else n_pass++;
  endtask

  task automatic test_neg_adjust_wrap();
    vid.hadj = 4'b1000;
    vid.vadj = 4'sd5;
    run_frame(36);
    n_chk++; if (vs_mask !== 20'hE0001) $display("FAIL neg_vs_deferred: got %h want e0001", vs_mask); else n_pass++;
    run_frame(28);
    n_chk++; if (hs_line !== 48'h0000F0000000) $display("FAIL neg_hs: got %h want 0000f0000000", hs_line); else n_pass++;
    n_chk++; if (vs_mask !== 20'h0003C) $display("FAIL neg_vs: got %h want 0003c", vs_mask); else n_pass++;
    n_chk++; if (vs_bad != 0) $display("FAIL neg_vs_align: %0d VS edges off hdump 28, want 0", vs_bad); else n_pass++;
    n_chk++; if (seq_err != 0) $display("FAIL neg_seq: %0d counter steps wrong, want 0", seq_err); else n_pass++;
    vid.hadj = '0;
    vid.vadj = '0;
  endtask

  task automatic test_ahead();
    goto(0, 17);
    n_chk++; if (vid.vrender !== 6'd19 || vid.vrender1 !== 6'd0)
      $display("FAIL ahead_17: got vrender=%0d vrender1=%0d want 19,0", vid.vrender, vid.vrender1); else n_pass++;
    goto(0, 18);
    n_chk++; if (vid.vrender !== 6'd0 || vid.vrender1 !== 6'd1)
      $display("FAIL ahead_18: got vrender=%0d vrender1=%0d want 0,1", vid.vrender, vid.vrender1); else n_pass++;
  endtask

  task automatic test_gate();
    logic [31:0] snap;
    int diffs;
    goto(37, 7);
    n_chk++; if ({vid.HS, vid.LHBL} !== 2'b10)
      $display("FAIL gate_flags: got HS,LHBL=%b want 10", {vid.HS, vid.LHBL}); else n_pass++;
    snap = {vid.hdump, vid.vdump, vid.vrender, vid.vrender1, vid.hinit, vid.vinit,
            vid.LHBL, vid.LVBL, vid.HS, vid.VS};
    diffs = 0;
    vid.pxl_cen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if ({vid.hdump, vid.vdump, vid.vrender, vid.vrender1, vid.hinit, vid.vinit,
           vid.LHBL, vid.LVBL, vid.HS, vid.VS} !== snap) diffs++;
    end
    n_chk++; if (diffs != 0) $display("FAIL gate_hold: %0d cycles changed, want 0", diffs); else n_pass++;
    vid.pxl_cen = 1'b1;
    step();
    n_chk++; if (vid.hdump !== 6'd38 || vid.vdump !== 6'd7)
      $display("FAIL gate_resume: got (%0d,%0d) want (38,7)", vid.hdump, vid.vdump); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rst_exp;
    rst_exp = {6'd0, 6'd0, 6'd2, 6'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    goto(20, 10);
    #3;
    rst_n = 1'b0;
    #1;
    n_chk++; if ({vid.hdump, vid.vdump, vid.vrender, vid.vrender1, vid.hinit, vid.vinit,
                  vid.LHBL, vid.LVBL, vid.HS, vid.VS} !== rst_exp)
      $display("FAIL rstmid_async: got hdump=%0d vdump=%0d vr=%0d vr1=%0d flags=%b", vid.hdump, vid.vdump,
               vid.vrender, vid.vrender1, {vid.hinit, vid.vinit, vid.LHBL, vid.LVBL, vid.HS, vid.VS});
    else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_chk++; if (vid.hdump !== 6'd1 || vid.vdump !== 6'd0)
      $display("FAIL rstmid_resume: got (%0d,%0d) want (1,0)", vid.hdump, vid.vdump); else n_pass++;
  endtask

  initial begin
    vid.pxl_cen = 1'b0;
    vid.hadj = '0;
    vid.vadj = '0;
    test_reset();
    test_free_run();
    test_adjust_deferred();
    test_neg_adjust_wrap();
    test_ahead();
    test_gate();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
